// File: rtl/csa_resolve.sv
// csa_resolve
// Resolves a carry-save pair (sum vector in_s, carry vector in_co of weight 2)
// into a plain binary value out_sum = in_s + 2*in_co. It is built as a segmented,
// pipelined carry-propagate adder that adds SEG bits per stage, with a
// valid/ready handshake and a tag carried through unchanged.
//
// Ports
//   clk        clock, rising edge
//   rstN       synchronous active-low reset
//   in_valid   input pair present
//   in_ready   pair accepted this cycle (= !out_valid | out_ready)
//   in_s       sum vector, CSAWIDTH bits
//   in_co      carry vector, CSAWIDTH bits, weight 2
//   in_tag     sideband tag, TAGW bits
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_sum    binary result, CSAWIDTH+2 bits, never truncated
//   out_tag    tag that was accepted with out_sum
module csa_resolve #(
  parameter int CSAWIDTH = 27,
  parameter int SEG      = 8,
  parameter int TAGW     = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CSAWIDTH-1:0]   in_s,
  input  logic [CSAWIDTH-1:0]   in_co,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CSAWIDTH+1:0]   out_sum,
  output logic [TAGW-1:0]       out_tag
);

  localparam int OUTW   = CSAWIDTH + 2;
  localparam int STAGES = (OUTW + SEG - 1) / SEG;

  // Per-stage state: both operands, the partially resolved result, the
  // carry out of the slice that stage added, the tag and a valid bit.
  logic [STAGES-1:0]                vld_q,   vld_d;
  logic [STAGES-1:0]                cy_q,    cy_d;
  logic [STAGES-1:0][OUTW-1:0]      opa_q,   opa_d;
  logic [STAGES-1:0][OUTW-1:0]      opb_q,   opb_d;
  logic [STAGES-1:0][OUTW-1:0]      res_q,   res_d;
  logic [STAGES-1:0][TAGW-1:0]      tag_q,   tag_d;

  // Global stall: the whole pipe moves only when the last stage can empty.
  logic advance_s;
  assign advance_s = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    // The top slice may be narrower than SEG.
    localparam int W  = ((OUTW - LO) < SEG) ? (OUTW - LO) : SEG;

    logic [OUTW-1:0] a_in_s;
    logic [OUTW-1:0] b_in_s;
    logic [OUTW-1:0] r_in_s;
    logic            c_in_s;
    logic [TAGW-1:0] t_in_s;
    logic            v_in_s;
    logic [W:0]      slice_s;
    logic [OUTW-1:0] r_new_s;

    if (k == 0) begin : g_first
      // Zero-extend both vectors; the carry vector enters already doubled.
      assign a_in_s = {2'b00, in_s};
      assign b_in_s = {1'b0, in_co, 1'b0};
      assign r_in_s = '0;
      assign c_in_s = 1'b0;
      assign t_in_s = in_tag;
      assign v_in_s = in_valid;
    end else begin : g_rest
      assign a_in_s = opa_q[k-1];
      assign b_in_s = opb_q[k-1];
      assign r_in_s = res_q[k-1];
      assign c_in_s = cy_q[k-1];
      assign t_in_s = tag_q[k-1];
      assign v_in_s = vld_q[k-1];
    end

    assign slice_s = {1'b0, a_in_s[LO +: W]} + {1'b0, b_in_s[LO +: W]}
                   + {{W{1'b0}}, c_in_s};

    // Splice this stage's resolved slice into the running result.
    always_comb begin
      r_new_s           = r_in_s;
      r_new_s[LO +: W]  = slice_s[W-1:0];
    end

    // The carry out of the top slice is always 0 and simply goes unused.
    assign res_d[k] = r_new_s;
    assign cy_d[k]  = slice_s[W];
    assign opa_d[k] = a_in_s;
    assign opb_d[k] = b_in_s;
    assign tag_d[k] = t_in_s;
    assign vld_d[k] = v_in_s;
  end

  // Pipeline registers: clear on reset, shift together on advance, else hold.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      vld_q <= '0;
      cy_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      tag_q <= '0;
    end else if (advance_s) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      tag_q <= tag_d;
    end else begin
      vld_q <= vld_q;
      cy_q  <= cy_q;
      opa_q <= opa_q;
      opb_q <= opb_q;
      res_q <= res_q;
      tag_q <= tag_q;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = res_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule
